mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin controller that shares one 32×32 radix-2 Booth multiplier core between two requesters. It accepts a signed operand pair from either requester and latches it. It sequences the core through start, run, done and clear, then returns the 64-bit product on a single tagged response channel. A watchdog aborts any operation that the core fails to complete.

## Interface
Parameters:
- TIMEOUT, 40: maximum cycles in RUN before the operation is aborted with error; must be ≥ 34.
- CW, 6: width of the watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 operand pair accepted this cycle
- req0_multiplier  in  32  requester 0 multiplier, two's complement
- req0_multiplicand  in  32  requester 0 multiplicand, two's complement
- req1_valid / req1_ready / req1_multiplier / req1_multiplicand: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  64  signed product
- rsp_err  out  1  watchdog abort; rsp_result is 0 when set
- mul_op_start  out  1  core start/run request
- mul_op_clear  out  1  core clear request
- mul_multiplier  out  32  operand to core
- mul_multiplicand  out  32  operand to core
- mul_op_done  in  1  core finished
- mul_result  in  64  core product

## Operation
- States are IDLE, RUN, CLR and RESP.
- **IDLE:** ready is driven combinationally: reqK_ready = (state==IDLE) && grant==K.
  - Grant rule: if only one valid is set, grant that requester. If both are set, grant the requester that is not last_grant.
  - On a handshake: latch the operands and id, set last_grant to the id, clear the watchdog, and go to RUN.
- **RUN:**
  - mul_op_start=1 and the latched operands are driven to the core. The watchdog increments each cycle.
  - If mul_op_done=1: capture mul_result, set err=0, go to CLR.
  - Else if the watchdog reaches TIMEOUT-1: set result to 0, err=1, go to CLR.
  - If mul_op_done and the timeout coincide, mul_op_done wins.
- **CLR:** mul_op_start=0 and mul_op_clear=1 for exactly one cycle, then go to RESP.
- **RESP:** rsp_valid=1 with rsp_id, rsp_result and rsp_err held stable.
  - On rsp_valid && rsp_ready, go to IDLE.
  - rsp_ready is ignored in every other state.
- Operands on mul_* stay stable from RUN entry through CLR exit. They hold their last value in IDLE and RESP.
- New requests are not accepted in RUN, CLR or RESP; both ready outputs are 0 there. Requesters must hold valid and data until they see ready.
- The operands' signedness is preserved. This block does no arithmetic on the product.

## Timing
- Reset (reset_n=0 at a rising edge) puts the block in IDLE.
  - Outputs reset to: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, mul_op_start=0, mul_op_clear=0, mul_multiplier=0, mul_multiplicand=0.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - Reset during RUN, CLR or RESP drops the transaction; no response is produced.
- Accept at cycle 0 gives RUN from cycle 1. The core is expected to assert mul_op_done after about 33 RUN cycles. Done at cycle N gives CLR at N+1 and rsp_valid at N+2.
- If rsp_ready is already high, the response completes at N+2 and IDLE can accept again at N+3.
- All state and outputs are registered, except reqK_ready, which is combinational from state, last_grant and the valids.

## Structure
- A shared package holds:
  - the state encoding (IDLE=2'b00, RUN=2'b01, CLR=2'b10, RESP=2'b11);
  - the core's state codes (start, multiple, clear);
  - the default TIMEOUT constant.
- A single sub-module, rr_arb2, is natural: a 2-way round-robin grant with a last_grant register and an update enable.
- The FSM, operand/result registers and watchdog stay in mul_arbiter.

## Test plan
- **Single request:** req0 gives 7 × -3 with rsp_ready=1.
  - rsp_result=64'hFFFFFFFFFFFFFFEB, rsp_id=0, rsp_err=0.
  - mul_op_clear pulses for exactly one cycle before rsp_valid.
- **Contention:** req0 and req1 valid together from reset (req0 = 2×3, req1 = -5×-5).
  - Responses arrive in order id0 with 6, then id1 with 25.
  - A second simultaneous pair is granted to req0, because last_grant=1.
- **Backpressure:** rsp_ready=0 for 10 cycles during RESP.
  - rsp_valid and rsp_result stay stable; ready outputs stay 0; completion happens when rsp_ready rises.
- **Watchdog:** the stub core never asserts mul_op_done.
  - After exactly TIMEOUT RUN cycles, the response has rsp_err=1 and rsp_result=0.
  - Also drive mul_op_done on the timeout cycle itself: the result is taken and err=0.
- **Reset mid-RUN:** reset_n=0 for one cycle, 10 cycles into RUN.
  - All outputs return to their reset values and no response is emitted.
  - The next req1 request completes normally.
- **Extremes:** 32'h80000000 × 32'h80000000 gives 64'h4000000000000000; 32'h7FFFFFFF × 32'h80000000 gives 64'hC000000080000000.

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// Shared types and defaults for the two-requester Booth multiplier arbiter.
package mul_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_CLR  = 2'b10,
    S_RESP = 2'b11
  } state_t;

  // State codes of the shared Booth core, kept here so both sides agree on them.
  typedef enum logic [1:0] {
    CORE_IDLE     = 2'b00,
    CORE_START    = 2'b01,
    CORE_MULTIPLE = 2'b10,
    CORE_CLEAR    = 2'b11
  } core_state_t;

  localparam int DEF_TIMEOUT = 40;
  localparam int DEF_CW      = 6;

endpackage

// File: rtl/mul_arbiter_if.sv
// Request, response and core-side signals of the multiplier arbiter.
interface mul_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_multiplier;
  logic [31:0] req0_multiplicand;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_multiplier;
  logic [31:0] req1_multiplicand;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_err;
  logic        mul_op_start;
  logic        mul_op_clear;
  logic [31:0] mul_multiplier;
  logic [31:0] mul_multiplicand;
  logic        mul_op_done;
  logic [63:0] mul_result;

  modport slave (
    input  req0_valid, req0_multiplier, req0_multiplicand,
    output req0_ready,
    input  req1_valid, req1_multiplier, req1_multiplicand,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    input  rsp_ready,
    output mul_op_start, mul_op_clear, mul_multiplier, mul_multiplicand,
    input  mul_op_done, mul_result
  );

  modport master (
    output req0_valid, req0_multiplier, req0_multiplicand,
    input  req0_ready,
    output req1_valid, req1_multiplier, req1_multiplicand,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    output rsp_ready,
    input  mul_op_start, mul_op_clear, mul_multiplier, mul_multiplicand,
    output mul_op_done, mul_result
  );
endinterface

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant advances only when the grant is consumed.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       update_en,
  output logic       grant,
  output logic       grant_valid
);

  logic last_grant;

  always_comb begin
    grant = valid[1];
    if (valid == 2'b11) grant = ~last_grant;
    grant_valid = valid[grant];
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset_n) last_grant <= 1'b1;
    else if (update_en) last_grant <= grant;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one Booth multiplier core between two requesters with a tagged response and a RUN watchdog.
//
// state | meaning
// IDLE  | waiting for a request; ready follows the round-robin grant
// RUN   | core running on latched operands; watchdog counting
// CLR   | one-cycle core clear after done or abort
// RESP  | response held until the consumer takes it
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = DEF_CW
) (
  input logic          clk,
  input logic          reset_n,
  mul_arbiter_if.slave bus
);

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wdog;
  logic          grant, grant_valid;
  logic          accept, wd_inc, cap_done, cap_abort;

  rr_arb2 u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .update_en  (accept),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  assign bus.req0_ready = (state == S_IDLE) && !grant;
  assign bus.req1_ready = (state == S_IDLE) &&  grant;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wd_inc    = 1'b0;
    cap_done  = 1'b0;
    cap_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A done on the last watchdog cycle still counts as a real result.
        if (bus.mul_op_done) begin
          cap_done  = 1'b1;
          state_nxt = S_CLR;
        end else if (wdog == WD_LAST) begin
          cap_abort = 1'b1;
          state_nxt = S_CLR;
        end else begin
          wd_inc = 1'b1;
        end
      end
      S_CLR:   state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog                 <= '0;
      bus.mul_op_start     <= 1'b0;
      bus.mul_op_clear     <= 1'b0;
      bus.mul_multiplier   <= '0;
      bus.mul_multiplicand <= '0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_id           <= 1'b0;
      bus.rsp_result       <= '0;
      bus.rsp_err          <= 1'b0;
    end else begin
      bus.mul_op_start <= (state_nxt == S_RUN);
      bus.mul_op_clear <= (state_nxt == S_CLR);
      bus.rsp_valid    <= (state_nxt == S_RESP);
      if (accept) begin
        wdog                 <= '0;
        bus.rsp_id           <= grant;
        bus.mul_multiplier   <= grant ? bus.req1_multiplier   : bus.req0_multiplier;
        bus.mul_multiplicand <= grant ? bus.req1_multiplicand : bus.req0_multiplicand;
      end else if (wd_inc) begin
        wdog <= wdog + CW'(1);
      end
      if (cap_done) begin
        bus.rsp_result <= bus.mul_result;
        bus.rsp_err    <= 1'b0;
      end else if (cap_abort) begin
        bus.rsp_result <= '0;
        bus.rsp_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: stub Booth core, expected-response queue, immediate assertions.
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  localparam int TIMEOUT = 40;

  typedef struct {
    logic        id;
    logic [63:0] res;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  mul_arbiter_if bus();

  mul_arbiter #(.TIMEOUT(TIMEOUT), .CW(6)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Stub core: done after done_at+1 RUN cycles when enabled, never otherwise.
  logic stub_en = 1'b1;
  int   done_at = 32;
  int   run_cnt = 0;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    return sa * sbv;
  endfunction

  always @(posedge clk) begin
    if (!bus.mul_op_start) run_cnt <= 0;
    else                   run_cnt <= run_cnt + 1;
  end
  assign bus.mul_op_done = stub_en && bus.mul_op_start && (run_cnt == done_at);
  assign bus.mul_result  = stub_en ? prod(bus.mul_multiplier, bus.mul_multiplicand)
                                   : 64'hDEAD_BEEF_0BAD_F00D;

  exp_t sb[$];
  int   n_pass = 0, n_total = 0;
  int   cyc_cnt = 0, start_cycles = 0, clr_cycles = 0, acc_cyc = 0, rsp_rise_cyc = 0, n_rsp = 0;
  logic prev_clr = 1'b0, prev_rsp = 1'b0, clr_before_rsp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_rsp(input logic id, input logic [63:0] res, input logic err);
    exp_t e;
    e.id = id; e.res = res; e.err = err;
    sb.push_back(e);
  endtask

  // One clock: sample at negedge, retire handshakes, drop accepted valids after the edge.
  task automatic cyc();
    logic a0, a1;
    exp_t e;
    @(negedge clk);
    cyc_cnt++;
    if (bus.mul_op_start) start_cycles++;
    if (bus.mul_op_clear) clr_cycles++;
    if (bus.rsp_valid && !prev_rsp) begin
      rsp_rise_cyc   = cyc_cnt;
      clr_before_rsp = prev_clr;
    end
    prev_clr = bus.mul_op_clear;
    prev_rsp = bus.rsp_valid;
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) chk("rsp_unexpected", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_result", bus.rsp_result, e.res);
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    if (a0 || a1) acc_cyc = cyc_cnt;
    @(posedge clk);
    #1;
    if (a0) bus.req0_valid = 1'b0;
    if (a1) bus.req1_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cyc();
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b);
    bus.req0_multiplier = a; bus.req0_multiplicand = b; bus.req0_valid = 1'b1;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b);
    bus.req1_multiplier = a; bus.req1_multiplicand = b; bus.req1_valid = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"},  64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_id"},     64'(bus.rsp_id), 64'd0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 64'd0);
    chk({tag, "_rsp_err"},    64'(bus.rsp_err), 64'd0);
    chk({tag, "_start"},      64'(bus.mul_op_start), 64'd0);
    chk({tag, "_clear"},      64'(bus.mul_op_clear), 64'd0);
    chk({tag, "_mplier"},     64'(bus.mul_multiplier), 64'd0);
    chk({tag, "_mcand"},      64'(bus.mul_multiplicand), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int base;
    bus.req0_valid = 1'b0; bus.req0_multiplier = '0; bus.req0_multiplicand = '0;
    bus.req1_valid = 1'b0; bus.req1_multiplier = '0; bus.req1_multiplicand = '0;
    bus.rsp_ready  = 1'b1;

    // Reset values
    repeat (2) cyc();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    cyc();

    // Single request 7 x -3 with latency and clear pulse
    start_cycles = 0; clr_cycles = 0;
    expect_rsp(1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    drive0(32'd7, 32'hFFFF_FFFD);
    drain(100);
    cyc();
    chk("single_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd35);
    chk("single_run_cycles", 64'(start_cycles), 64'd33);
    chk("single_clr_cycles", 64'(clr_cycles), 64'd1);
    chk("single_clr_before_rsp", 64'(clr_before_rsp), 64'd1);
    chk("operand_hold_idle", 64'(bus.mul_multiplier), 64'd7);

    // Contention from reset, then a second simultaneous pair
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    expect_rsp(1'b0, 64'd6, 1'b0);
    expect_rsp(1'b1, 64'd25, 1'b0);
    drive0(32'd2, 32'd3);
    drive1(32'hFFFF_FFFB, 32'hFFFF_FFFB);
    drain(200);
    expect_rsp(1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 1'b0);
    expect_rsp(1'b1, 64'd16, 1'b0);
    drive0(32'd100, 32'hFFFF_FFFF);
    drive1(32'd4, 32'd4);
    drain(200);

    // Backpressure: response held 10 cycles while req0 waits
    bus.rsp_ready = 1'b0;
    expect_rsp(1'b1, -64'sd97406784, 1'b0);
    drive1(32'd123456, -32'sd789);
    for (int i = 0; i < 100 && !bus.rsp_valid; i++) cyc();
    chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    expect_rsp(1'b0, -64'sd12, 1'b0);
    drive0(32'd3, -32'sd4);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid_held", 64'(bus.rsp_valid), 64'd1);
      chk("bp_result_held", bus.rsp_result, -64'sd97406784);
      chk("bp_req0_ready", 64'(bus.req0_ready), 64'd0);
      chk("bp_req1_ready", 64'(bus.req1_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    drain(200);

    // Watchdog abort, then done on the timeout cycle
    stub_en = 1'b0; start_cycles = 0;
    expect_rsp(1'b0, 64'd0, 1'b1);
    drive0(32'd9, 32'd9);
    drain(200);
    chk("wd_run_cycles", 64'(start_cycles), 64'(TIMEOUT));
    stub_en = 1'b1; done_at = TIMEOUT - 1; start_cycles = 0;
    expect_rsp(1'b1, -64'sd100, 1'b0);
    drive1(-32'sd2, 32'd50);
    drain(200);
    chk("wd_coincide_run_cycles", 64'(start_cycles), 64'(TIMEOUT));
    done_at = 32;

    // Reset 10 cycles into RUN drops the transaction
    start_cycles = 0;
    drive0(32'd5, 32'd5);
    for (int i = 0; i < 50 && start_cycles < 10; i++) cyc();
    chk("mid_run_reached", 64'(start_cycles), 64'd10);
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    check_reset_outputs("mid_reset");
    base = n_rsp;
    repeat (60) cyc();
    chk("mid_reset_no_rsp", 64'(n_rsp - base), 64'd0);
    expect_rsp(1'b1, -64'sd121, 1'b0);
    drive1(32'd11, -32'sd11);
    drain(200);

    // Extremes
    expect_rsp(1'b0, 64'h4000_0000_0000_0000, 1'b0);
    drive0(32'h8000_0000, 32'h8000_0000);
    drain(200);
    expect_rsp(1'b1, 64'hC000_0000_8000_0000, 1'b0);
    drive1(32'h7FFF_FFFF, 32'h8000_0000);
    drain(200);

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
